// File: rtl/scope_meas_sched.sv
// Measurement-window scheduler: hold-off, min/max/crossing accumulation over
// a fixed number of accepted samples, then result hand-off over valid/ready.
module scope_meas_sched #(
  parameter int unsigned WIN_LEN     = 1_000_000,
  parameter int unsigned HOLD_OFF    = 16,
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter int unsigned HYST        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        single,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_max,
  output logic [7:0]  res_min,
  output logic [23:0] res_cross,
  output logic        res_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HOLDOFF, ACQ, REPORT} state_t;

  localparam logic [31:0] WIN_LAST = 32'(WIN_LEN - 1);
  localparam logic [31:0] HO_LAST  = (HOLD_OFF > 0) ? 32'(HOLD_OFF - 1) : '0;
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [9:0]  HYST_W   = 10'(HYST);
  localparam state_t      FIRST_ST = (HOLD_OFF == 0) ? ACQ : HOLDOFF;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] cyc;
  logic [7:0]  thr;
  logic        armed;

  logic        start, ho_take, acq_take, win_done, to_hit, cyc_hit;
  logic [7:0]  max_nxt, min_nxt, thr_mid, hi, lo;
  logic [9:0]  hi_w;

  // State register plus registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state_nxt == REPORT);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ho_take   = 1'b0;
    acq_take  = 1'b0;
    win_done  = 1'b0;
    to_hit    = 1'b0;
    cyc_hit   = (cyc == TO_LAST);
    unique case (state)
      IDLE: begin
        if (run || single) begin
          start     = 1'b1;
          state_nxt = FIRST_ST;
        end
      end
      HOLDOFF: begin
        ho_take = sample_valid;
        if (cyc_hit) begin
          to_hit    = 1'b1;
          state_nxt = REPORT;
        end else if (sample_valid && cnt == HO_LAST) begin
          state_nxt = ACQ;
        end
      end
      ACQ: begin
        acq_take = sample_valid;
        // the final sample beats a coincident timeout
        if (sample_valid && cnt == WIN_LAST) begin
          win_done  = 1'b1;
          state_nxt = REPORT;
        end else if (cyc_hit) begin
          to_hit    = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (run) begin
            start     = 1'b1;
            state_nxt = FIRST_ST;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  // Accumulator next values, hysteresis window and next threshold
  always_comb begin
    max_nxt = (sample > res_max) ? sample : res_max;
    min_nxt = (sample < res_min) ? sample : res_min;
    thr_mid = 8'(({1'b0, max_nxt} + {1'b0, min_nxt}) >> 1);
    hi_w    = {2'b00, thr} + HYST_W;
    hi      = (hi_w > 10'd255) ? 8'hFF : hi_w[7:0];
    lo      = ({2'b00, thr} < HYST_W) ? 8'h00 : (thr - HYST_W[7:0]);
  end

  // Window counters, accumulators (which are the result registers) and threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cyc         <= '0;
      res_max     <= '0;
      res_min     <= '1;
      res_cross   <= '0;
      res_timeout <= 1'b0;
      armed       <= 1'b0;
      thr         <= 8'd128;
    end else if (start) begin
      cnt         <= '0;
      cyc         <= '0;
      res_max     <= '0;
      res_min     <= '1;
      res_cross   <= '0;
      res_timeout <= 1'b0;
      armed       <= 1'b0;
    end else begin
      if (state == HOLDOFF || state == ACQ) cyc <= cyc + 32'd1;
      if (ho_take) cnt <= (cnt == HO_LAST) ? '0 : cnt + 32'd1;
      if (acq_take) begin
        cnt     <= cnt + 32'd1;
        res_max <= max_nxt;
        res_min <= min_nxt;
        if (armed && sample >= hi) begin
          if (res_cross != '1) res_cross <= res_cross + 24'd1;
          armed <= 1'b0;
        end else if (sample <= lo) begin
          armed <= 1'b1;
        end
      end
      if (to_hit) res_timeout <= 1'b1;
      if (win_done) thr <= thr_mid;
    end
  end

endmodule

// File: doc/scope_meas_sched.md
# scope_meas_sched

Measurement-window scheduler for the oscilloscope front end. It sequences acquisition windows over the 8-bit sample stream: hold-off, min/max/crossing accumulation over a fixed sample count, then result hand-off. Results go to the display/auto-range logic over a valid/ready handshake. It sits between the ADC sample path (after clipping) and the voltage/frequency readout logic. It replaces free-running, unsynchronised window counters with one controlled measurement cycle.

## Interface
- WIN_LEN, 1_000_000: accepted samples per measurement window (≥1)
- HOLD_OFF, 16: accepted samples discarded after each window start (≥0)
- TIMEOUT_CYC, 5_000_000: max clk cycles spent in HOLDOFF+ACQ before forced report
- HYST, 4: crossing hysteresis in LSBs
- clk  in  1  system clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- run  in  1  continuous mode: re-arm after every reported window
- single  in  1  one-cycle pulse: start one window from IDLE
- sample_valid  in  1  sample qualifier
- sample  in  8  unsigned sample
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_max / res_min  out  8 each  window extrema
- res_cross  out  24  hysteretic rising crossings of threshold in window (saturating)
- res_timeout  out  1  window ended by timeout
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, HOLDOFF, ACQ, REPORT.
- IDLE: `run` or `single` high → HOLDOFF (→ ACQ directly if HOLD_OFF=0). Clears the accumulators, the sample counter and the cycle counter.
- HOLDOFF: counts accepted samples and discards them. The HOLD_OFF-th sample → ACQ.
- ACQ: each accepted sample updates the accumulators:
  - max ← max(max, s); min ← min(min, s); accumulators start at max=0, min=255.
  - The WIN_LEN-th sample → REPORT; that sample is included.
- Crossing detector:
  - Armed when s ≤ lo; a crossing is counted when armed and s ≥ hi; a counted crossing disarms.
  - Armed flag is cleared at window start.
  - res_cross saturates at 2^24−1.
- Threshold `thr`, 8 bits:
  - Reset value 128.
  - At each non-timeout REPORT entry: thr ← (max+min)>>1, computed in 9 bits.
  - hi = min(thr+HYST, 255); lo = max(thr−HYST, 0), both saturating.
  - A new thr applies to the next window only.
- Timeout:
  - The cycle counter runs in HOLDOFF and ACQ.
  - Reaching TIMEOUT_CYC−1 → REPORT with res_timeout=1, partial stats, thr unchanged.
  - If the final sample and the timeout fall on the same cycle, window completion wins: res_timeout=0.
- REPORT:
  - res_valid=1; all res_* held stable until res_valid&&res_ready.
  - On transfer: run=1 → HOLDOFF with new window; otherwise → IDLE.
  - Samples arriving during REPORT and IDLE are dropped.
- `single` outside IDLE is ignored.
- `run` deasserted mid-window: the current window completes and reports, then → IDLE.
- Reset values: state IDLE; res_valid 0, res_max 0, res_min 255, res_cross 0, res_timeout 0, busy 0, thr 128.
- Asynchronous reset mid-window: all state is lost immediately; no partial result is emitted.

## Timing
- Start is seen in IDLE at edge N → busy=1 and state HOLDOFF/ACQ from N+1. The first sample counted is the one valid at N+1.
- Last window sample accepted at edge M → res_valid=1 from M+1, with res_* including that sample.
- Transfer at edge T → res_valid=0 from T+1.
- With run=1, a new window accepts samples from T+1; there are no gap cycles.
- res_ready may be held high permanently, giving a one-cycle REPORT.
- res_* outputs are registered; there is no combinational path from input to output.

## Test plan
- HOLD_OFF=2, WIN_LEN=4, single pulse, samples 9,9,10,200,50,30 → one result: max=200, min=10, timeout=0; next thr=105; state returns to IDLE.
- run=1, WIN_LEN=8, triangle 0→255→0 with thr=128, HYST=4 → res_cross=1 per rising pass. A square wave 100/160 gives crossings = number of rising edges after the first low.
- res_ready held low for 20 cycles while samples keep arriving → res_* stable, samples dropped. On ready, next window starts at T+1 with fresh min=255/max=0.
- sample_valid never asserted, TIMEOUT_CYC=10 → REPORT at cycle 10 with res_timeout=1, max=0, min=255, cross=0; thr stays 128.
- Last sample coincident with timeout expiry → res_timeout=0, full stats.
- rst asserted mid-ACQ → res_valid=0 and busy=0 immediately; after release with run=1, the next window is clean.
